// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PAR_ODD=1).
module uart_rx_deserializer #(
  parameter int unsigned PRESCALE = 16,
  parameter bit          PAR_ODD  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          cnt_half, cnt_full;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
`endif

  assign rxs      = sync_q[1];
  assign cnt_half = (cnt_q == HALF_M1);
  assign cnt_full = (cnt_q == FULL_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!rxs) state_d = START;
        START:   if (cnt_half) state_d = rxs ? IDLE : DATA;
        DATA: begin
          if (cnt_full && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY:  if (cnt_full) state_d = STOP;
`endif
        STOP:    if (cnt_full) state_d = rxs ? IDLE : RECOVER;
        RECOVER: if (rxs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (!rx_en) begin
      cnt_d = '0;
      bit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          bit_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
        START: cnt_d = cnt_half ? '0 : cnt_q + CNT_ONE;
        DATA: begin
          if (cnt_full) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_full) begin
            cnt_d     = '0;
            par_bad_d = (rxs != (^shift_q ^ PAR_ODD));
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_full) begin
            cnt_d = '0;
            // frame error outranks a parity error on the same byte
            if (!rxs) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RECOVER: cnt_d = '0;
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: expected pulses (kind, data,
// arrival cycle) are queued when a frame is driven and matched by a monitor.
module tb_uart_rx_deserializer;

  localparam int unsigned P = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 2 + P / 2 + 10 * P;
`else
  localparam int unsigned LAT = 2 + P / 2 + 9 * P;
`endif
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  logic [7:0]  last_good = 8'h00;
  exp_t        sb[$];

  uart_rx_deserializer #(.PRESCALE(P), .PAR_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] obs;
    obs = {parity_err, frame_err, data_valid};
    if (rst && (obs != 3'b000)) begin
      check("pulse_onehot", $countones(obs), 1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, obs}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {29'd0, obs}, {29'd0, e.kind});
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_data", {24'd0, data_out}, {24'd0, e.data});
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (P) @(negedge clk);
  endtask

  // call at a negedge; the start bit is first seen at the following posedge
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input logic [2:0] kind);
    exp_t e;
    if (kind != 3'b000) begin
      e.kind = kind;
      e.data = (kind == K_VALID) ? d : last_good;
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
      if (kind == K_VALID) last_good = d;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) rx_in = 1'b1;
`endif
    send_bit(stop_b);
    rx_in = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0, K_VALID);
    check("a5_data_out", {24'd0, data_out}, 32'hA5);
    check("a5_busy_after", {31'd0, busy}, 0);
    repeat (4) @(negedge clk);

    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 0);
    check("glitch_data_out", {24'd0, data_out}, 32'hA5);

    send_frame(8'h3C, 1'b0, 1'b0, K_FERR);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    check("recover_busy", {31'd0, busy}, 1);
    check("recover_data_out", {24'd0, data_out}, 32'hA5);
    rx_in = 1'b1;
    repeat (6) @(negedge clk);
    check("recover_exit_busy", {31'd0, busy}, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, K_PERR);
    repeat (4) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1, K_VALID);
    check("par_ok_data_out", {24'd0, data_out}, 32'h07);
    repeat (4) @(negedge clk);
`endif

    fork
      send_frame(8'h55, 1'b1, 1'b0, 3'b000);
      begin
        repeat (5 * P + P / 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_data_out", {24'd0, data_out}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_valid", {31'd0, data_valid}, 0);
        check("midrst_ferr", {31'd0, frame_err}, 0);
        last_good = 8'h00;
      end
    join
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 0);
    send_frame(8'h81, 1'b1, 1'b0, K_VALID);
    check("x81_data_out", {24'd0, data_out}, 32'h81);

    send_frame(8'h00, 1'b1, 1'b0, K_VALID);
    send_frame(8'hFF, 1'b1, 1'b0, K_VALID);
    fork
      send_frame(8'h5A, 1'b1, 1'b0, 3'b000);
      begin
        repeat (5 * P) @(negedge clk);
        rx_en = 1'b0;
      end
    join
    repeat (2 * P) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_data_out", {24'd0, data_out}, 32'hFF);
    rx_en = 1'b1;
    repeat (3 * P) @(negedge clk);

    check("sb_pending", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16: clk cycles per bit; even, >= 4.
REQ-002 SHALL have parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_RX_PARITY_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx_en  input  1  receive enable.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port data_out  output  8  last received byte.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when a good byte is available.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse when the parity bit mismatches.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer, with both flops reset to 1; all FSM decisions use the synchronized value rxs.
REQ-013 SHALL frame data as 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and RECOVER.
REQ-015 IDLE: when rxs == 0 and rx_en == 1, SHALL go to START and clear the cycle counter.
REQ-016 START: at cycle count PRESCALE/2-1, SHALL resample rxs; if 0, go to DATA; if 1 (glitch), go to IDLE with no output pulse.
REQ-017 DATA: SHALL sample rxs into the shift register at cycle count PRESCALE-1, then clear the counter and increment the 3-bit bit counter.
REQ-018 DATA: after bit 7, SHALL go to PARITY if parity is compiled in, otherwise to STOP.
REQ-019 STOP: SHALL sample rxs at count PRESCALE-1.
REQ-020 STOP, stop bit 1 and no parity error: SHALL load data_out from the shift register, pulse data_valid, and go to IDLE.
REQ-021 STOP, stop bit 0: SHALL pulse frame_err, leave data_out unchanged, keep data_valid low, and go to RECOVER.
REQ-022 RECOVER: SHALL wait until rxs == 1, then go to IDLE; a line held low SHALL never start a new frame.
REQ-023 data_valid, frame_err and parity_err SHALL be registered, high for exactly one cycle, and mutually exclusive.
REQ-024 Latency: with rx_in first sampled low at edge E0, the result pulse SHALL be high in the cycle after edge E0 + 2 + PRESCALE/2 + 9*PRESCALE, plus PRESCALE when parity is compiled in.
REQ-025 rx_en low in any state SHALL force IDLE on the next edge, abort any frame in progress, and produce no pulse; data_out SHALL be held.
REQ-026 The cycle counter SHALL be sized ceil(log2(PRESCALE)) bits and SHALL never wrap past PRESCALE-1.
REQ-027 Back-to-back frames SHALL be accepted: a start edge detected on the cycle following a return to IDLE SHALL be honoured.

Reset
REQ-028 When rst is low, outputs SHALL be: data_out = 0x00, data_valid = 0, frame_err = 0, parity_err = 0, busy = 0.
REQ-029 When rst is low, the FSM SHALL be in IDLE, counters and the shift register SHALL be 0, and the synchronizer SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL take effect immediately, without waiting for clk; after release, the block SHALL wait for a fresh start edge.

Configuration
REQ-031 The macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-032 With UART_RX_PARITY_EN defined: the PARITY state SHALL sample at count PRESCALE-1 and compare against the XOR of the data bits, inverted when PAR_ODD = 1.
REQ-033 With UART_RX_PARITY_EN defined, on mismatch: the STOP bit SHALL still be sampled; parity_err SHALL pulse instead of data_valid, data_out SHALL be unchanged, and frame_err SHALL take precedence if the stop bit is also 0.
REQ-034 Without UART_RX_PARITY_EN: the PARITY state SHALL be unreachable or absent, parity_err SHALL be tied to 0, and PAR_ODD SHALL be ignored.

Verification
REQ-035 PRESCALE=16, no parity, frame 0xA5 -> data_out = 0xA5; data_valid high only in the cycle after edge 154; busy low afterwards.
REQ-036 rx_in low for 3 cycles, then high -> START aborts to IDLE; no pulse; data_out unchanged.
REQ-037 Frame 0x3C with stop bit 0, then line held low 40 cycles -> one frame_err pulse; state stays RECOVER until rx_in goes high; no spurious start.
REQ-038 UART_RX_PARITY_EN defined, PAR_ODD=0, byte 0x07 with parity bit 0 -> parity_err pulse, data_valid 0; same byte with parity bit 1 -> data_valid, data_out = 0x07.
REQ-039 rst pulled low during data bit 4 of a frame -> all outputs 0 immediately; after release, next frame 0x81 -> data_out = 0x81.
REQ-040 Frames 0x00 then 0xFF back-to-back with no idle gap, and rx_en dropped mid-third frame -> two data_valid pulses, data_out = 0xFF, no third pulse.
